// File: rtl/dma_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and limits for the CPU/DMA memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_OWN, DMA_OWN} owner_t;
  typedef enum logic {TAG_CPU, TAG_DMA} tag_t;
  localparam int MAX_RD_LATENCY = 4;
endpackage

// File: rtl/dma_mem_arbiter_if.sv
// dma_mem_arbiter_if: CPU, DMA and memory-port signals of the arbiter.
interface dma_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic                  dma_req, dma_we, dma_last, dma_gnt, dma_rvalid;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata, dma_rdata;
  logic                  mem_en, mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  logic                  dma_owner;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_last, dma_addr, dma_wdata, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, dma_owner
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_last, dma_addr, dma_wdata, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, dma_owner
  );
endinterface

// File: rtl/dma_mem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: read-return owner tag delay line matching the memory read latency.
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  tag_t in_tag,
  output logic out_valid,
  output tag_t out_tag
);
  logic [DEPTH-1:0] v, t;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v <= '0;
      t <= '0;
    end else begin
      v <= (v << 1) | DEPTH'(in_valid);
      t <= (t << 1) | DEPTH'(in_tag);
    end
  assign out_valid = v[DEPTH-1];
  assign out_tag   = tag_t'(t[DEPTH-1]);
endmodule

// File: rtl/dma_mem_arbiter.sv
// dma_mem_arbiter: shares the single-port data memory between CPU and DMA line engine.
module dma_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_BEATS = 16,
  parameter int RD_LATENCY  = 1
) (
  input logic clk,
  input logic rst_n,
  dma_mem_arbiter_if.slave bus
);
  localparam int CW = BURST_BEATS > 1 ? $clog2(BURST_BEATS) : 1;
  localparam logic [CW-1:0] CAP = CW'(BURST_BEATS - 1);
  localparam int PIPE_D = RD_LATENCY > MAX_RD_LATENCY ? MAX_RD_LATENCY : RD_LATENCY < 1 ? 1 : RD_LATENCY;
  owner_t                state, state_n;
  logic                  last_dma, cpu_gnt, dma_gnt, dma_end, en_q, we_q, rd_v;
  logic [CW-1:0]         beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  tag_t                  tag_q, rd_tag;
  assign cpu_gnt = state == CPU_OWN && bus.cpu_req;
  assign dma_gnt = state == DMA_OWN && bus.dma_req;
  // a dropped request ends ownership as well as dma_last or the line-length cap
  assign dma_end = !bus.dma_req || bus.dma_last || beat_cnt == CAP;
  always_comb
    state_n = state == CPU_OWN ? (bus.dma_req ? DMA_OWN : bus.cpu_req ? CPU_OWN : IDLE) :
              state == DMA_OWN ? (!dma_end ? DMA_OWN : bus.cpu_req ? CPU_OWN : bus.dma_req ? DMA_OWN : IDLE) :
              bus.cpu_req && (!bus.dma_req || last_dma) ? CPU_OWN : bus.dma_req ? DMA_OWN : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      last_dma <= 1'b0;
      beat_cnt <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tag_q    <= TAG_CPU;
    end else begin
      state    <= state_n;
      last_dma <= state == IDLE ? last_dma : state == DMA_OWN;
      beat_cnt <= state == DMA_OWN && !dma_end ? beat_cnt + 1'b1 : '0;
      en_q     <= cpu_gnt || dma_gnt;
      we_q     <= cpu_gnt ? bus.cpu_we : dma_gnt && bus.dma_we;
      addr_q   <= cpu_gnt ? bus.cpu_addr : dma_gnt ? bus.dma_addr : addr_q;
      wdata_q  <= cpu_gnt ? bus.cpu_wdata : dma_gnt ? bus.dma_wdata : wdata_q;
      tag_q    <= dma_gnt ? TAG_DMA : TAG_CPU;
    end
  rd_tag_pipe #(.DEPTH(PIPE_D)) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (en_q && !we_q),
    .in_tag   (tag_q),
    .out_valid(rd_v),
    .out_tag  (rd_tag)
  );
  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.mem_en     = en_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.dma_owner  = state == DMA_OWN;
  assign bus.cpu_rvalid = rd_v && rd_tag == TAG_CPU;
  assign bus.dma_rvalid = rd_v && rd_tag == TAG_DMA;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_dma_mem_arbiter.sv
// tb_dma_mem_arbiter: directed checks of grant order, line capping, read return and reset.
module tb_dma_mem_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, failures = 0;
  dma_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  dma_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_BEATS(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) bus.mem_rdata <= '0;
    else bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? f(bus.mem_addr) : '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic cr, input logic [31:0] ca, input logic dr, input logic dl, input logic [31:0] da);
    @(negedge clk);
    bus.cpu_req = cr; bus.cpu_addr = ca; bus.cpu_wdata = ~ca;
    bus.dma_req = dr; bus.dma_last = dl; bus.dma_addr = da; bus.dma_wdata = ~da;
    #1;
  endtask
  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dma_req = 0; bus.dma_we = 0; bus.dma_last = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dma_gnt", bus.dma_gnt, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_owner", bus.dma_owner, 0);
    chk("rst_rdata", bus.cpu_rdata, bus.mem_rdata);
    @(negedge clk) rst_n = 1'b1;
    // lone CPU read: IDLE bubble, grant, memory cycle, return
    cyc(1, 32'h100, 0, 0, 0); chk("t1_bubble", bus.cpu_gnt, 0);
    cyc(1, 32'h100, 0, 0, 0); chk("t1_gnt", bus.cpu_gnt, 1); chk("t1_en0", bus.mem_en, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_en", bus.mem_en, 1); chk("t1_we", bus.mem_we, 0); chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_rv_early", bus.cpu_rvalid, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t1_rvalid", bus.cpu_rvalid, 1); chk("t1_rdata", bus.cpu_rdata, f(32'h100));
    chk("t1_dma_rv", bus.dma_rvalid, 0); chk("t1_en_off", bus.mem_en, 0);
    cyc(0, 0, 0, 0, 0); chk("t1_rv_once", bus.cpu_rvalid, 0);
    // simultaneous requests after CPU service: DMA goes first
    cyc(1, 32'h200, 1, 0, 32'h6000); chk("t4_idle_c", bus.cpu_gnt, 0); chk("t4_idle_d", bus.dma_gnt, 0);
    cyc(1, 32'h200, 1, 0, 32'h6000);
    chk("t4_dma_first", bus.dma_gnt, 1); chk("t4_cpu_wait", bus.cpu_gnt, 0); chk("t4_owner", bus.dma_owner, 1);
    cyc(1, 32'h200, 1, 1, 32'h6004); chk("t4_beat2", bus.dma_gnt, 1); chk("t4_addr0", bus.mem_addr, 32'h6000);
    cyc(1, 32'h200, 0, 0, 0);
    chk("t4_cpu_gnt", bus.cpu_gnt, 1); chk("t4_owner_off", bus.dma_owner, 0);
    chk("t4_drv0", bus.dma_rvalid, 1); chk("t4_drd0", bus.dma_rdata, f(32'h6000));
    cyc(0, 0, 0, 0, 0);
    chk("t4_drv1", bus.dma_rvalid, 1); chk("t4_drd1", bus.dma_rdata, f(32'h6004));
    chk("t4_crv_early", bus.cpu_rvalid, 0); chk("t4_caddr", bus.mem_addr, 32'h200);
    cyc(0, 0, 0, 0, 0);
    chk("t4_crv", bus.cpu_rvalid, 1); chk("t4_crd", bus.cpu_rdata, f(32'h200)); chk("t4_drv_off", bus.dma_rvalid, 0);
    // 16-beat DMA write line
    bus.dma_we = 1;
    cyc(0, 0, 1, 0, 32'h5000); chk("t2_bubble", bus.dma_gnt, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 1, i == 15, 32'h5000 + 4 * i);
      chk("t2_gnt", bus.dma_gnt, 1);
      if (i > 0) begin
        chk("t2_addr", bus.mem_addr, 32'h5000 + 4 * (i - 1));
        chk("t2_wdata", bus.mem_wdata, ~(32'h5000 + 4 * (i - 1)));
        chk("t2_we", bus.mem_we, 1);
      end
    end
    cyc(0, 0, 0, 0, 0);
    chk("t2_nogrant", bus.dma_gnt, 0); chk("t2_last_addr", bus.mem_addr, 32'h503C); chk("t2_dma_rv", bus.dma_rvalid, 0);
    cyc(0, 0, 0, 0, 0); chk("t2_idle", bus.dma_owner, 0); chk("t2_en_off", bus.mem_en, 0);
    // simultaneous requests after DMA line: CPU first; CPU waits out a line
    cyc(1, 32'h240, 1, 0, 32'h7000); chk("t5_idle", bus.cpu_gnt, 0);
    cyc(1, 32'h240, 1, 0, 32'h7000); chk("t5_cpu_first", bus.cpu_gnt, 1); chk("t5_dma_wait", bus.dma_gnt, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(i >= 3, 32'h300, 1, i == 15, 32'h7000 + 4 * i);
      chk("t3_dma_gnt", bus.dma_gnt, 1);
      chk("t3_cpu_blocked", bus.cpu_gnt, 0);
      if (i == 1) begin
        chk("t5_crv", bus.cpu_rvalid, 1);
        chk("t5_crd", bus.cpu_rdata, f(32'h240));
      end
    end
    cyc(1, 32'h300, 1, 1, 32'h7040);
    chk("t3_cpu_gnt", bus.cpu_gnt, 1); chk("t3_next_wait", bus.dma_gnt, 0); chk("t3_owner", bus.dma_owner, 0);
    cyc(0, 0, 1, 1, 32'h7040);
    chk("t3_next_line", bus.dma_gnt, 1); chk("t3_caddr", bus.mem_addr, 32'h300); chk("t3_cwe", bus.mem_we, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t3_crv", bus.cpu_rvalid, 1); chk("t3_crd", bus.cpu_rdata, f(32'h300)); chk("t3_nogrant", bus.dma_gnt, 0);
    // DMA without dma_last: capped at 16 beats, CPU slips in, DMA resumes
    cyc(0, 0, 1, 0, 32'h8000); chk("t6_bubble", bus.dma_gnt, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(i >= 10, 32'h400, 1, 0, 32'h8000 + 4 * i);
      chk("t6_gnt", bus.dma_gnt, 1);
      chk("t6_cpu_blocked", bus.cpu_gnt, 0);
    end
    cyc(1, 32'h400, 1, 0, 32'h8040); chk("t6_cap_cpu", bus.cpu_gnt, 1); chk("t6_cap_dma", bus.dma_gnt, 0);
    for (int i = 16; i < 20; i++) begin
      cyc(0, 0, 1, 0, 32'h8000 + 4 * i);
      chk("t6_resume", bus.dma_gnt, 1);
      if (i == 16) chk("t6_caddr", bus.mem_addr, 32'h400);
      if (i == 17) chk("t6_crv", bus.cpu_rvalid, 1);
    end
    cyc(0, 0, 0, 0, 0);
    chk("t6_nogrant", bus.dma_gnt, 0); chk("t6_owner", bus.dma_owner, 1); chk("t6_addr", bus.mem_addr, 32'h804C);
    // two reads in flight, then reset
    bus.dma_we = 0;
    cyc(1, 32'h500, 1, 1, 32'h9000); chk("t7_idle", bus.cpu_gnt, 0);
    cyc(1, 32'h500, 1, 1, 32'h9000); chk("t7_cpu_gnt", bus.cpu_gnt, 1);
    cyc(0, 0, 1, 1, 32'h9000); chk("t7_dma_gnt", bus.dma_gnt, 1); chk("t7_caddr", bus.mem_addr, 32'h500);
    @(negedge clk);
    rst_n = 1'b0;
    bus.dma_req = 0; bus.dma_last = 0;
    #1;
    chk("t7_rst_en", bus.mem_en, 0); chk("t7_rst_crv", bus.cpu_rvalid, 0); chk("t7_rst_drv", bus.dma_rvalid, 0);
    chk("t7_rst_owner", bus.dma_owner, 0); chk("t7_rst_addr", bus.mem_addr, 0); chk("t7_rst_wdata", bus.mem_wdata, 0);
    @(negedge clk) rst_n = 1'b1;
    bus.cpu_req = 1; bus.cpu_addr = 32'h600;
    #1;
    chk("t7_post_idle", bus.cpu_gnt, 0); chk("t7_post_crv", bus.cpu_rvalid, 0); chk("t7_post_drv", bus.dma_rvalid, 0);
    cyc(1, 32'h600, 0, 0, 0); chk("t7_post_gnt", bus.cpu_gnt, 1); chk("t7_post_drv2", bus.dma_rvalid, 0);
    cyc(0, 0, 0, 0, 0); chk("t7_post_crv2", bus.cpu_rvalid, 0); chk("t7_post_addr", bus.mem_addr, 32'h600);
    cyc(0, 0, 0, 0, 0); chk("t7_post_crv3", bus.cpu_rvalid, 1); chk("t7_post_crd", bus.cpu_rdata, f(32'h600));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
